// File: rtl/ericsmi_speed_pkg.sv
// Shared types and constants for the ericsmi_speed_test measurement host.
package ericsmi_speed_pkg;

  typedef enum logic [3:0] {
    IDLE, RESET, ARM, TRIG, SETTLE, FIRECHK, READ, EVAL, FINISH
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_PREFIRED = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd2;
  localparam logic [2:0] ERR_SMALL    = 3'd3;
  localparam logic [2:0] ERR_MISMATCH = 3'd4;
  localparam logic [2:0] ERR_OVERFLOW = 3'd5;

  localparam logic [2:0] SEL_IDLE   = 3'd0;
  localparam logic [2:0] SEL_C0_B0  = 3'd1;
  localparam logic [2:0] SEL_C0_B1  = 3'd2;
  localparam logic [2:0] SEL_C0_B2  = 3'd3;
  localparam logic [2:0] SEL_C1_B0  = 3'd4;
  localparam logic [2:0] SEL_C1_B1  = 3'd5;
  localparam logic [2:0] SEL_C1_B2  = 3'd6;
  localparam logic [2:0] SEL_STATUS = 3'd7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ericsmi_speed_eval.sv
// Combinational result checker: classifies a raw counter pair and converts it
// to elapsed-cycle counts (the DUT counters run down from 0xFFFFFF).
module ericsmi_speed_eval
  import ericsmi_speed_pkg::*;
#(
  parameter int MIN_COUNT = 10,
  parameter int MAX_DIFF  = 3
) (
  input  logic [23:0] raw0,
  input  logic [23:0] raw1,
  output logic [2:0]  err_code,
  output logic [23:0] count0,
  output logic [23:0] count1
);

  logic [23:0] diff;

  // Prioritised checks: small count beats mismatch beats overflow.
  always_comb begin
    diff   = (raw0 >= raw1) ? (raw0 - raw1) : (raw1 - raw0);
    count0 = 24'hFFFFFF - raw0;
    count1 = 24'hFFFFFF - raw1;
    if ((raw0 < 24'(MIN_COUNT)) || (raw1 < 24'(MIN_COUNT))) begin
      err_code = ERR_SMALL;
    end else if (diff > 24'(MAX_DIFF)) begin
      err_code = ERR_MISMATCH;
    end else if (!raw0[23] || !raw1[23]) begin
      err_code = ERR_OVERFLOW;
    end else begin
      err_code = ERR_NONE;
    end
  end

endmodule

// File: rtl/ericsmi_speed_host.sv
// Measurement sequencer for ericsmi_speed_test: reset, arm, trigger, settle,
// stop rings, check fired flag, read six bytes, evaluate.
module ericsmi_speed_host
  import ericsmi_speed_pkg::*;
#(
  parameter int RST_CYCLES    = 2,
  parameter int TRIG_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int SEL_WAIT      = 1,
  parameter int FIRE_TIMEOUT  = 16,
  parameter int MIN_COUNT     = 10,
  parameter int MAX_DIFF      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  dut_out,
  output logic        dut_nrst,
  output logic        dut_trig,
  output logic [2:0]  dut_sel,
  output logic [1:0]  dut_ring_en,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_code,
  output logic [23:0] count0,
  output logic [23:0] count1
);

  localparam int CNT_MAX = max2(max2(RST_CYCLES, TRIG_CYCLES),
                                max2(SETTLE_CYCLES, SEL_WAIT + FIRE_TIMEOUT));
  localparam int CW = $clog2(CNT_MAX) + 1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0]    idx, idx_n;
  logic [23:0]   raw0, raw1, raw0_n, raw1_n;
  logic          nrst_n, trig_n, busy_n, done_n, pass_n;
  logic [2:0]    sel_n, err_n, e_err;
  logic [1:0]    ring_n;
  logic [23:0]   count0_n, count1_n, e_c0, e_c1;

  ericsmi_speed_eval #(.MIN_COUNT(MIN_COUNT), .MAX_DIFF(MAX_DIFF)) u_eval (
    .raw0(raw0), .raw1(raw1), .err_code(e_err), .count0(e_c0), .count1(e_c1)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;        cnt <= '0;          idx <= 3'd0;
      raw0 <= 24'd0;        raw1 <= 24'd0;
      dut_nrst <= 1'b0;     dut_trig <= 1'b0;   dut_sel <= SEL_IDLE;
      dut_ring_en <= 2'b00; busy <= 1'b0;       done <= 1'b0;
      pass <= 1'b0;         err_code <= ERR_NONE;
      count0 <= 24'd0;      count1 <= 24'd0;
    end else begin
      state <= state_n;     cnt <= cnt_n;       idx <= idx_n;
      raw0 <= raw0_n;       raw1 <= raw1_n;
      dut_nrst <= nrst_n;   dut_trig <= trig_n; dut_sel <= sel_n;
      dut_ring_en <= ring_n; busy <= busy_n;    done <= done_n;
      pass <= pass_n;       err_code <= err_n;
      count0 <= count0_n;   count1 <= count1_n;
    end
  end

  // Next state, datapath updates, and outputs decoded from the next state.
  always_comb begin
    cnt_inc  = (cnt == '1) ? cnt : cnt + CW'(1);
    state_n  = state;  cnt_n  = cnt_inc; idx_n = idx;
    raw0_n   = raw0;   raw1_n = raw1;    err_n = err_code; pass_n = pass;
    count0_n = count0; count1_n = count1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = RESET; err_n = ERR_NONE; pass_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      RESET: begin
        if (cnt == CW'(RST_CYCLES - 1)) begin state_n = ARM; cnt_n = '0; end
        else begin state_n = RESET; end
      end
      // First ARM cycle lets the DUT see the new controls; second samples.
      ARM: begin
        if (cnt == CW'(1)) begin
          cnt_n = '0;
          if (dut_out[6]) begin state_n = FINISH; err_n = ERR_PREFIRED; end
          else begin state_n = TRIG; end
        end else begin
          state_n = ARM;
        end
      end
      TRIG: begin
        if (cnt == CW'(TRIG_CYCLES - 1)) begin state_n = SETTLE; cnt_n = '0; end
        else begin state_n = TRIG; end
      end
      SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin state_n = FIRECHK; cnt_n = '0; end
        else begin state_n = SETTLE; end
      end
      FIRECHK: begin
        if (cnt >= CW'(SEL_WAIT)) begin
          if (dut_out[6]) begin
            state_n = READ; idx_n = SEL_C0_B0; cnt_n = '0;
          end else if (cnt == CW'(SEL_WAIT + FIRE_TIMEOUT - 1)) begin
            state_n = FINISH; err_n = ERR_TIMEOUT; cnt_n = '0;
          end else begin
            state_n = FIRECHK;
          end
        end else begin
          state_n = FIRECHK;
        end
      end
      READ: begin
        if (cnt == CW'(SEL_WAIT)) begin
          cnt_n = '0;
          case (idx)
            SEL_C0_B0: raw0_n[7:0]   = dut_out;
            SEL_C0_B1: raw0_n[15:8]  = dut_out;
            SEL_C0_B2: raw0_n[23:16] = dut_out;
            SEL_C1_B0: raw1_n[7:0]   = dut_out;
            SEL_C1_B1: raw1_n[15:8]  = dut_out;
            SEL_C1_B2: raw1_n[23:16] = dut_out;
            default:   raw0_n        = raw0;
          endcase
          if (idx == SEL_C1_B2) begin state_n = EVAL; end
          else begin idx_n = idx + 3'd1; end
        end else begin
          state_n = READ;
        end
      end
      EVAL: begin
        state_n = FINISH; err_n = e_err; count0_n = e_c0; count1_n = e_c1;
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n == FINISH) pass_n = (err_n == ERR_NONE);
    else pass_n = pass_n;

    nrst_n = 1'b1; trig_n = 1'b0; sel_n = SEL_IDLE; ring_n = 2'b00;
    busy_n = 1'b1; done_n = 1'b0;
    case (state_n)
      IDLE:    busy_n = 1'b0;
      RESET:   nrst_n = 1'b0;
      ARM:     ring_n = 2'b11;
      TRIG:    begin trig_n = 1'b1; ring_n = 2'b11; end
      SETTLE:  ring_n = 2'b11;
      FIRECHK: sel_n = SEL_STATUS;
      READ:    sel_n = idx_n;
      EVAL:    sel_n = SEL_IDLE;
      FINISH:  begin busy_n = 1'b0; done_n = 1'b1; end
      default: busy_n = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ericsmi_speed_host.sv
// Directed bench for ericsmi_speed_host with a behavioural ring-oscillator model.
module tb_ericsmi_speed_host;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  dut_out;
  logic        dut_nrst, dut_trig, busy, done, pass;
  logic [2:0]  dut_sel, err_code;
  logic [1:0]  dut_ring_en;
  logic [23:0] count0, count1;

  int checks = 0;
  int errors = 0;

  logic [23:0] m_raw0, m_raw1;
  logic [1:0]  m_mode;  // 0: fires after rings stop, 1: never fires, 2: fired already at arm
  logic        seen_trig, fired;
  int          trig_cnt = 0;
  int          readsel_cnt = 0;

  ericsmi_speed_host dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
    .dut_nrst(dut_nrst), .dut_trig(dut_trig), .dut_sel(dut_sel),
    .dut_ring_en(dut_ring_en), .busy(busy), .done(done), .pass(pass),
    .err_code(err_code), .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!dut_nrst) begin
      seen_trig <= 1'b0;
      fired     <= 1'b0;
    end else begin
      if (dut_trig) seen_trig <= 1'b1;
      if (m_mode == 2'd0 && seen_trig && dut_ring_en == 2'b00) fired <= 1'b1;
    end
  end

  always_comb begin
    case (dut_sel)
      3'd1:    dut_out = m_raw0[7:0];
      3'd2:    dut_out = m_raw0[15:8];
      3'd3:    dut_out = m_raw0[23:16];
      3'd4:    dut_out = m_raw1[7:0];
      3'd5:    dut_out = m_raw1[15:8];
      3'd6:    dut_out = m_raw1[23:16];
      default: dut_out = {1'b0, (fired === 1'b1) || (m_mode == 2'd2), 6'b000000};
    endcase
  end

  always @(negedge clk) begin
    if (dut_trig) trig_cnt <= trig_cnt + 1;
    if (dut_sel >= 3'd1 && dut_sel <= 3'd6) readsel_cnt <= readsel_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch a run, also poke start while busy, then check the result at done.
  task automatic run(input string tag, input int exp_lat, input logic exp_pass,
                     input logic [2:0] exp_err, input logic [23:0] exp_c0,
                     input logic [23:0] exp_c1);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (n == 10) start = 1'b1;
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    check({tag, "_err"}, 32'(err_code), 32'(exp_err));
    check({tag, "_count0"}, 32'(count0), 32'(exp_c0));
    check({tag, "_count1"}, 32'(count1), 32'(exp_c1));
    check({tag, "_ring_en"}, 32'(dut_ring_en), 32'd0);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_start_at_done_ignored"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_nrst"}, 32'(dut_nrst), 32'd0);
    check({tag, "_trig"}, 32'(dut_trig), 32'd0);
    check({tag, "_sel"}, 32'(dut_sel), 32'd0);
    check({tag, "_ring"}, 32'(dut_ring_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_code), 32'd0);
    check({tag, "_c0"}, 32'(count0), 32'd0);
    check({tag, "_c1"}, 32'(count1), 32'd0);
  endtask

  initial begin
    int t0;
    bit found;
    rst = 1'b1; start = 1'b0; m_mode = 2'd0;
    m_raw0 = 24'hFFFF00; m_raw1 = 24'hFFFF02;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_nrst", 32'(dut_nrst), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    run("nominal", 25, 1'b1, 3'd0, 24'h0000FF, 24'h0000FD);

    m_raw1 = 24'hFFFF04;
    run("mismatch", 25, 1'b0, 3'd4, 24'h0000FF, 24'h0000FB);

    m_raw0 = 24'h7FFFF0; m_raw1 = 24'h7FFFF0;
    run("overflow", 25, 1'b0, 3'd5, 24'h80000F, 24'h80000F);

    m_raw0 = 24'h000005; m_raw1 = 24'h000005;
    run("small", 25, 1'b0, 3'd3, 24'hFFFFFA, 24'hFFFFFA);

    m_mode = 2'd1;
    m_raw0 = 24'hFFFF00; m_raw1 = 24'hFFFF02;
    t0 = readsel_cnt;
    run("timeout", 27, 1'b0, 3'd2, 24'hFFFFFA, 24'hFFFFFA);
    check("timeout_no_read_sel", readsel_cnt - t0, 0);

    m_mode = 2'd2;
    t0 = trig_cnt;
    run("prefire", 5, 1'b0, 3'd1, 24'hFFFFFA, 24'hFFFFFA);
    check("prefire_no_trig", trig_cnt - t0, 0);

    m_mode = 2'd0;
    @(negedge clk);
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (dut_sel == 3'd3) found = 1'b1;
    end
    check("midrun_reached_idx3", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    m_raw0 = 24'hFFFF10; m_raw1 = 24'hFFFF11;
    run("after_rst", 25, 1'b1, 3'd0, 24'h0000EF, 24'h0000EE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ericsmi_speed_host.md
Name: ericsmi_speed_host

Overview:
- Hardware measurement host for the ericsmi_speed_test ring-oscillator block. It runs the full measurement protocol in hardware: reset, arm, trigger, settle, stop the rings, check the fired flag, read out six bytes, evaluate.
- Drives the DUT's packed io_in control fields and samples its 8-bit io_out.
- Reports two converted cycle counts plus pass/error status.
- Used on an FPGA carrier or as a synthesizable self-test companion, replacing manual bench sequencing.

Parameters:
- RST_CYCLES, 2, cycles dut_nrst is held low at measurement start.
- TRIG_CYCLES, 2, cycles dut_trig is held high.
- SETTLE_CYCLES, 3, cycles after trig deasserts before the rings stop.
- SEL_WAIT, 1, cycles between a dut_sel change and sampling dut_out (minimum 1).
- FIRE_TIMEOUT, 16, cycles to wait for dut_out[6] before flagging an error.
- MIN_COUNT, 10, minimum raw counter value accepted.
- MAX_DIFF, 3, maximum allowed |raw0 - raw1|.

Ports:
- clk, input, 1, system clock. Also forwarded to the DUT clock input at top level.
- rst, input, 1, reset. Asynchronous, active-high.
- start, input, 1, single-cycle pulse; ignored while busy.
- dut_out, input, 8, DUT io_out. Bit 7 is the debug/status bit, bit 6 the fired flag, and bits 7:0 the readout byte when sel is 1..6.
- dut_nrst, output, 1, DUT active-low reset.
- dut_trig, output, 1, DUT measurement trigger.
- dut_sel, output, 3, DUT output mux select.
- dut_ring_en, output, 2, ring oscillator enables.
- busy, output, 1, high from start acceptance until done.
- done, output, 1, single-cycle pulse at the end of evaluation.
- pass, output, 1, holds the result of the last run.
- err_code, output, 3, holds the error code of the last run.
- count0, output, 24, 0xFFFFFF - raw0, held until the next run.
- count1, output, 24, 0xFFFFFF - raw1, held until the next run.

Behaviour:
- Reset values: dut_nrst=0, dut_trig=0, dut_sel=0, dut_ring_en=0, busy=0, done=0, pass=0, err_code=0, count0=0, count1=0, state=IDLE.
- All outputs are registered. dut_out is sampled on the clk rising edge only.
- State IDLE:
  - Outputs as reset, except dut_nrst=1.
  - On start=1: busy=1, pass and err_code clear, go to RESET.
- State RESET:
  - dut_nrst=0, sel=0, ring_en=0 for RST_CYCLES cycles.
  - Then go to ARM.
- State ARM (1 cycle drive, sample the next cycle):
  - Drive dut_nrst=1, sel=0, ring_en=3.
  - If dut_out[6]=1, set err=1 and go to FINISH.
  - Otherwise go to TRIG.
- State TRIG: dut_trig=1 for TRIG_CYCLES cycles, then go to SETTLE.
- State SETTLE:
  - dut_trig=0 for SETTLE_CYCLES cycles.
  - Then drive ring_en=0, sel=7 and go to FIRECHK.
- State FIRECHK:
  - Wait SEL_WAIT cycles, then poll dut_out[6] each cycle.
  - On 1, go to READ with idx=1.
  - If FIRE_TIMEOUT cycles elapse with no 1, set err=2 and go to FINISH.
- State READ:
  - Drive sel=idx and wait SEL_WAIT cycles, then capture dut_out into byte slot idx.
  - Slot mapping: 1 → raw0[7:0], 2 → raw0[15:8], 3 → raw0[23:16], 4 → raw1[7:0], 5 → raw1[15:8], 6 → raw1[23:16].
  - After idx=6, go to EVAL.
  - Total READ duration is 6*(SEL_WAIT+1) cycles.
- State EVAL (1 cycle). Checks run in this order; the first failure sets err:
  - raw0 < MIN_COUNT or raw1 < MIN_COUNT → err=3.
  - |raw0 - raw1| > MAX_DIFF → err=4. The subtraction is unsigned 24-bit with the larger value minuend.
  - raw0[23]=0 or raw1[23]=0 → err=5 (overflow).
  - count0 and count1 are loaded in EVAL regardless of the outcome.
- State FINISH:
  - Drive sel=0, ring_en=0, dut_trig=0.
  - done pulses for 1 cycle; pass=(err==0); busy drops in the same cycle.
  - Return to IDLE.
- ring_en is never 3 outside ARM..SETTLE. Every error path forces ring_en=0 within 1 cycle.
- start while busy: ignored, with no queueing.
- start in the same cycle as done: ignored; it must be re-issued.
- rst mid-run: all outputs return immediately (asynchronously) to their reset values. count and pass values from previous runs are lost.
- Cycle counters are sized with $clog2 of the largest parameter plus 1. They saturate, never wrap.

Decomposition:
- Package ericsmi_speed_pkg holds:
  - state enum (IDLE, RESET, ARM, TRIG, SETTLE, FIRECHK, READ, EVAL, FINISH);
  - err_code localparams (ERR_NONE=0, ERR_PREFIRED=1, ERR_TIMEOUT=2, ERR_SMALL=3, ERR_MISMATCH=4, ERR_OVERFLOW=5);
  - sel constants (SEL_STATUS=7, SEL_C0_B0=1 .. SEL_C1_B2=6).
- One sub-module, ericsmi_speed_eval: combinational checker taking raw0/raw1 and producing err_code and the converted counts. It is reused by bench scoreboards.

Test Plan:
- The behavioural DUT model returns raw0=0xFFFF00, raw1=0xFFFF02, fired after the settle phase. Required response: done after the full sequence, count0=0x0000FF, count1=0x0000FD, pass=1, err_code=0.
- raw0=0xFFFF00, raw1=0xFFFF04 → err_code=4, pass=0, counts are still loaded, ring_en=0 at done.
- The model never sets out[6] → err_code=2 exactly FIRE_TIMEOUT cycles after the FIRECHK wait ends. No READ sel values (1..6) ever appear on dut_sel.
- raw0=raw1=0x7FFFF0 → err_code=5. raw0=raw1=0x000005 → err_code=3, because the small-count check has priority.
- The model holds out[6]=1 during ARM → err_code=1, and dut_trig never rises.
- rst pulsed during READ idx=3 → all outputs reset asynchronously. A start issued 2 cycles later completes with pass=1, and count values match the new model data.
